// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
//   Groups every fetch-controller signal other than clock and reset.
//   master : the fetch controller (drives requests, buffer writes, flush)
//   slave  : the surroundings (imem, instruction buffer, backend)
//   Ports carried:
//     redirect_val / redirect_pc          backend flush + 8-byte aligned target
//     imem_req_val / imem_req_addr / rdy  fetch request handshake
//     imem_rec_val / imem_rec_packet      in-order fetch responses
//     buf_wr_val / buf_wr_pc / packet     writes into the instruction buffer
//     buf_flush / buf_deq                 buffer flush and consume strobe
interface fetch_ctrl_if #(
    parameter int CPU_ADDR_BITS = 32,
    parameter int FETCH_WIDTH   = 2
);
    logic                         redirect_val;
    logic [CPU_ADDR_BITS-1:0]     redirect_pc;
    logic                         imem_req_val;
    logic [CPU_ADDR_BITS-1:0]     imem_req_addr;
    logic                         imem_req_rdy;
    logic                         imem_rec_val;
    logic [FETCH_WIDTH*32-1:0]    imem_rec_packet;
    logic                         buf_wr_val;
    logic [CPU_ADDR_BITS-1:0]     buf_wr_pc;
    logic [FETCH_WIDTH*32-1:0]    buf_wr_packet;
    logic                         buf_flush;
    logic                         buf_deq;

    modport master (
        input  redirect_val, redirect_pc, imem_req_rdy, imem_rec_val,
               imem_rec_packet, buf_deq,
        output imem_req_val, imem_req_addr, buf_wr_val, buf_wr_pc,
               buf_wr_packet, buf_flush
    );

    modport slave (
        output redirect_val, redirect_pc, imem_req_rdy, imem_rec_val,
               imem_rec_packet, buf_deq,
        input  imem_req_val, imem_req_addr, buf_wr_val, buf_wr_pc,
               buf_wr_packet, buf_flush
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction fetch controller. Issues sequential packet fetches to imem,
//   limited by free instruction-buffer slots (credits) and by the number of
//   in-flight requests. Responses come back in order and are written to the
//   buffer tagged with the PC remembered in a small in-order queue. A backend
//   redirect flushes the buffer, retargets fetch and drops every response
//   still in flight; while such drops are pending the controller sits in
//   DRAIN and issues nothing.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    fetch_ctrl_if.master (imem, buffer and redirect signals)
module fetch_ctrl #(
    parameter int                       CPU_ADDR_BITS     = 32,
    parameter int                       FETCH_WIDTH       = 2,
    parameter int                       INST_BUFFER_DEPTH = 8,
    parameter int                       MAX_OUTSTANDING   = 2,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC          = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    localparam int STRIDE = 4 * FETCH_WIDTH;
    localparam int ALIGN  = $clog2(STRIDE);
    localparam int CRED_W = $clog2(INST_BUFFER_DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(INST_BUFFER_DEPTH - 1);
    localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [CPU_ADDR_BITS-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CRED_W-1:0]        credits_reg, credits_next;
    logic [OUT_W-1:0]         outstanding_reg, outstanding_next;
    logic [OUT_W-1:0]         drop_reg, drop_next;
    logic [PTR_W-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CPU_ADDR_BITS-1:0] pc_q [MAX_OUTSTANDING];

    logic req_val;
    logic req_fire;
    logic rsp_fire;
    logic wr_val;
    logic deq_eff;

    // A response with nothing tracked (e.g. a stale one crossing a reset)
    // is ignored so the queue pointers and counters cannot underflow.
    assign rsp_fire = bus.imem_rec_val && (outstanding_reg != '0);
    assign req_val  = rst_n && (state_reg == RUN) && (credits_reg != '0)
                      && (outstanding_reg < OUT_MAX) && !bus.redirect_val;
    assign req_fire = req_val && bus.imem_req_rdy;
    assign wr_val   = rst_n && rsp_fire && (drop_reg == '0) && !bus.redirect_val;
    // The buffer is being flushed, so a consume in that cycle frees nothing.
    assign deq_eff  = bus.buf_deq && !bus.redirect_val;

    assign bus.imem_req_val  = req_val;
    assign bus.imem_req_addr = fetch_pc_reg;
    assign bus.buf_wr_val    = wr_val;
    assign bus.buf_wr_pc     = wr_val ? pc_q[rd_ptr_reg] : '0;
    assign bus.buf_wr_packet = wr_val ? bus.imem_rec_packet : '0;
    assign bus.buf_flush     = rst_n && bus.redirect_val;

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        credits_next     = credits_reg;
        drop_next        = drop_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        outstanding_next = outstanding_reg + OUT_W'(req_fire) - OUT_W'(rsp_fire);

        if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + CPU_ADDR_BITS'(STRIDE);
            wr_ptr_next   = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (rsp_fire) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        end

        if (bus.redirect_val) begin
            fetch_pc_next = {bus.redirect_pc[CPU_ADDR_BITS-1:ALIGN], {ALIGN{1'b0}}};
            credits_next  = CRED_INIT;
            // Everything still in flight after this cycle belongs to the
            // old path; a response landing now is already being discarded.
            drop_next     = outstanding_reg - OUT_W'(rsp_fire);
        end else begin
            credits_next = credits_reg - CRED_W'(req_fire) + CRED_W'(deq_eff);
            if (rsp_fire && (drop_reg != '0)) begin
                drop_next = drop_reg - 1'b1;
            end
        end

        unique case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     if (bus.redirect_val && (drop_next != '0)) state_next = DRAIN;
            DRAIN:   if (drop_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            credits_reg     <= CRED_INIT;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            credits_reg     <= credits_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    // PC queue storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pc_q[wr_ptr_reg] <= fetch_pc_reg;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. An in-order imem model with programmable
//   latency answers accepted requests; every cycle's outputs are logged and
//   then compared against hand-computed expectations per scenario.
module tb_fetch_ctrl;
    logic clk;
    logic rst_n;

    fetch_ctrl_if #(.CPU_ADDR_BITS(32), .FETCH_WIDTH(2)) bif ();

    fetch_ctrl #(
        .CPU_ADDR_BITS(32),
        .FETCH_WIDTH(2),
        .INST_BUFFER_DEPTH(8),
        .MAX_OUTSTANDING(2),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    int          cyc;
    int          lat;
    logic        rdy;
    logic        deq;
    logic        redir;
    logic [31:0] redir_pc;

    logic [31:0] mdl_addr [$];
    int          mdl_due  [$];

    logic [31:0] acc_addr [$];
    int          acc_cyc  [$];
    logic [31:0] wr_pc    [$];
    logic [63:0] wr_pkt   [$];
    int          wr_cyc   [$];

    logic        val_at   [0:255];
    logic [31:0] addr_at  [0:255];
    logic        flush_at [0:255];
    logic [1:0]  state_at [0:255];

    function automatic logic [63:0] mk_pkt(input logic [31:0] a);
        return {~a, a ^ 32'h1357_9BDF};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs at posedge+1, sample at posedge+3,
    // then advance the imem model across the edge.
    task automatic run_cycle();
        logic took_rsp;
        logic took_req;
        logic [31:0] a;
        if (mdl_addr.size() > 0 && mdl_due[0] <= cyc) begin
            bif.imem_rec_val    = 1'b1;
            bif.imem_rec_packet = mk_pkt(mdl_addr[0]);
        end else begin
            bif.imem_rec_val    = 1'b0;
            bif.imem_rec_packet = '0;
        end
        bif.redirect_val = redir;
        bif.redirect_pc  = redir_pc;
        bif.buf_deq      = deq;
        bif.imem_req_rdy = rdy;
        #2;
        if (cyc < 256) begin
            val_at[cyc]   = bif.imem_req_val;
            addr_at[cyc]  = bif.imem_req_addr;
            flush_at[cyc] = bif.buf_flush;
            state_at[cyc] = dut.state_reg;
        end
        took_req = bif.imem_req_val && rdy;
        took_rsp = bif.imem_rec_val;
        a        = bif.imem_req_addr;
        if (took_req) begin
            acc_addr.push_back(a);
            acc_cyc.push_back(cyc);
            $display("[TB] cyc %0d req addr 0x%08h", cyc, a);
        end
        if (bif.buf_wr_val) begin
            wr_pc.push_back(bif.buf_wr_pc);
            wr_pkt.push_back(bif.buf_wr_packet);
            wr_cyc.push_back(cyc);
            $display("[TB] cyc %0d buf_wr pc 0x%08h pkt 0x%016h", cyc, bif.buf_wr_pc, bif.buf_wr_packet);
        end
        @(posedge clk);
        #1;
        if (took_rsp) begin
            void'(mdl_addr.pop_front());
            void'(mdl_due.pop_front());
        end
        if (took_req) begin
            mdl_addr.push_back(a);
            mdl_due.push_back(cyc + lat);
        end
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Asserts reset mid-cycle, checks outputs immediately, clears the model
    // and logs, and releases reset so that the next run_cycle is cycle 0.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_req_val"}, bif.imem_req_val, 1'b0);
        check({tag, "_rst_req_addr"}, bif.imem_req_addr, 32'h0);
        check({tag, "_rst_wr_val"}, bif.buf_wr_val, 1'b0);
        check({tag, "_rst_flush"}, bif.buf_flush, 1'b0);
        check({tag, "_rst_wr_pc"}, bif.buf_wr_pc, 32'h0);
        check({tag, "_rst_wr_pkt"}, bif.buf_wr_packet, 64'h0);
        check({tag, "_rst_state"}, dut.state_reg, 2'd0);
        mdl_addr.delete();
        mdl_due.delete();
        bif.imem_rec_val    = 1'b0;
        bif.imem_rec_packet = '0;
        redir = 1'b0;
        deq   = 1'b0;
        rdy   = 1'b1;
        bif.redirect_val = 1'b0;
        bif.buf_deq      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        acc_addr.delete();
        acc_cyc.delete();
        wr_pc.delete();
        wr_pkt.delete();
        wr_cyc.delete();
        cyc   = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        cyc      = 0;
        lat      = 3;
        rdy      = 1'b1;
        deq      = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'h0;
        bif.redirect_val    = 1'b0;
        bif.redirect_pc     = '0;
        bif.imem_req_rdy    = 1'b1;
        bif.imem_rec_val    = 1'b0;
        bif.imem_rec_packet = '0;
        bif.buf_deq         = 1'b0;
        @(posedge clk);
        #1;

        // A: latency 3 -> two requests, stall, writes 0x0 then 0x8
        $display("[TB] scenario A: latency 3 startup");
        do_reset("A");
        lat = 3;
        run_n(6);
        check("A_boot_val", val_at[0], 1'b0);
        check("A_acc0_addr", acc_addr[0], 32'h0);
        check("A_acc0_cyc", acc_cyc[0], 1);
        check("A_acc1_addr", acc_addr[1], 32'h8);
        check("A_val_c3", val_at[3], 1'b0);
        check("A_val_c4", val_at[4], 1'b0);
        check("A_acc2_addr", acc_addr[2], 32'h10);
        check("A_acc2_cyc", acc_cyc[2], 5);
        check("A_wr0_pc", wr_pc[0], 32'h0);
        check("A_wr0_cyc", wr_cyc[0], 4);
        check("A_wr0_pkt", wr_pkt[0], mk_pkt(32'h0));
        check("A_wr1_pc", wr_pc[1], 32'h8);

        // B: credit exhaustion then a single deq frees one request
        $display("[TB] scenario B: credit limit");
        do_reset("B");
        lat = 1;
        run_n(12);
        check("B_acc_count", acc_addr.size(), 7);
        check("B_acc6_addr", acc_addr[6], 32'h30);
        check("B_acc6_cyc", acc_cyc[6], 7);
        check("B_val_c8", val_at[8], 1'b0);
        check("B_val_c11", val_at[11], 1'b0);
        deq = 1'b1;
        run_cycle();
        deq = 1'b0;
        run_n(4);
        check("B_acc_count2", acc_addr.size(), 8);
        check("B_acc7_addr", acc_addr[7], 32'h38);
        check("B_acc7_cyc", acc_cyc[7], 13);
        check("B_val_c15", val_at[15], 1'b0);
        check("B_wr_count", wr_pc.size(), 8);
        check("B_wr6_pc", wr_pc[6], 32'h30);

        // C: redirect with two outstanding -> DRAIN, both dropped
        $display("[TB] scenario C: redirect with 2 outstanding");
        do_reset("C");
        lat = 3;
        run_n(3);
        redir    = 1'b1;
        redir_pc = 32'h100;
        run_cycle();
        redir = 1'b0;
        run_n(4);
        check("C_flush_c3", flush_at[3], 1'b1);
        check("C_flush_c4", flush_at[4], 1'b0);
        check("C_state_c4", state_at[4], 2'd2);
        check("C_val_c5", val_at[5], 1'b0);
        check("C_wr_count", wr_pc.size(), 0);
        check("C_acc2_addr", acc_addr[2], 32'h100);
        check("C_acc2_cyc", acc_cyc[2], 6);

        // D: redirect coincident with the only response, low bits masked
        $display("[TB] scenario D: redirect with coincident response");
        do_reset("D");
        lat = 3;
        run_n(2);
        rdy = 1'b0;
        run_n(2);
        redir    = 1'b1;
        redir_pc = 32'h203;
        run_cycle();
        redir = 1'b0;
        rdy   = 1'b1;
        run_n(2);
        check("D_hold_c2", addr_at[2], 32'h8);
        check("D_hold_c3", addr_at[3], 32'h8);
        check("D_flush_c4", flush_at[4], 1'b1);
        check("D_wr_count", wr_pc.size(), 0);
        check("D_state_c5", state_at[5], 2'd1);
        check("D_acc1_addr", acc_addr[1], 32'h200);
        check("D_acc1_cyc", acc_cyc[1], 5);

        // E: imem not ready for 5 cycles
        $display("[TB] scenario E: rdy low");
        do_reset("E");
        lat = 3;
        rdy = 1'b0;
        run_n(6);
        check("E_val_c5", val_at[5], 1'b1);
        check("E_addr_c1", addr_at[1], 32'h0);
        check("E_addr_c5", addr_at[5], 32'h0);
        check("E_fetch_pc", dut.fetch_pc_reg, 32'h0);
        check("E_credits", dut.credits_reg, 7);
        check("E_acc_none", acc_addr.size(), 0);
        rdy = 1'b1;
        run_cycle();
        check("E_acc_count", acc_addr.size(), 1);
        check("E_acc0_cyc", acc_cyc[0], 6);

        // F: reset asserted while in DRAIN with a response on the bus
        $display("[TB] scenario F: reset during DRAIN");
        do_reset("F0");
        lat = 3;
        run_n(3);
        redir    = 1'b1;
        redir_pc = 32'h100;
        run_cycle();
        redir = 1'b0;
        run_cycle();
        check("F_state_drain", state_at[4], 2'd2);
        do_reset("F");
        run_n(6);
        check("F_acc0_addr", acc_addr[0], 32'h0);
        check("F_acc0_cyc", acc_cyc[0], 1);
        check("F_wr_count", wr_pc.size(), 2);
        check("F_wr0_cyc", wr_cyc[0], 4);
        check("F_wr1_pc", wr_pc[1], 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
